// File: rtl/sqnxt_conv_addr_seq_if.sv
// rtl/sqnxt_conv_addr_seq_if.sv - control, beat and write-back signals of the conv address sequencer
interface sqnxt_conv_addr_seq_if #(
  parameter int ADDR_W  = 10,
  parameter int WADDR_W = 8
);
  logic               start;
  logic [1:0]         mode;
  logic               stall;
  logic               busy;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               pad;
  logic [WADDR_W-1:0] w_addr;
  logic               acc_clr;
  logic               acc_last;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               done;

  modport master (
    output start, mode, stall,
    input  busy, rd_en, rd_addr, pad, w_addr, acc_clr, acc_last, wr_en, wr_addr, done
  );

  modport slave (
    input  start, mode, stall,
    output busy, rd_en, rd_addr, pad, w_addr, acc_clr, acc_last, wr_en, wr_addr, done
  );
endinterface

// File: rtl/sqnxt_conv_addr_seq.sv
// rtl/sqnxt_conv_addr_seq.sv - SqueezeNext conv layer address/control sequencer (1x1, 3x1, 1x3)
module sqnxt_conv_addr_seq #(
  parameter int FM_W     = 8,
  parameter int CH_IN    = 8,
  parameter int CH_OUT   = 8,
  parameter int ADDR_W   = 10,
  parameter int WADDR_W  = 8,
  parameter int PIPE_LAT = 5
) (
  input logic                  clk,
  input logic                  rst,
  sqnxt_conv_addr_seq_if.slave bus
);
  localparam int FM2  = FM_W * FM_W;
  localparam int CO_W = (CH_OUT > 1) ? $clog2(CH_OUT) : 1;
  localparam int CI_W = (CH_IN > 1) ? $clog2(CH_IN) : 1;
  localparam int P_W  = $clog2(FM_W);
  localparam int D_W  = $clog2(PIPE_LAT + 1);

  if (CH_IN * FM2 > (1 << ADDR_W) || CH_OUT * FM2 > (1 << ADDR_W)) begin : g_addr_chk
    $error("sqnxt_conv_addr_seq: feature map does not fit in ADDR_W");
  end
  if (FM_W < 2 || PIPE_LAT < 1) begin : g_param_chk
    $error("sqnxt_conv_addr_seq: FM_W must be >=2 and PIPE_LAT >=1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [CO_W-1:0]    co;
  logic [P_W-1:0]     y, x;
  logic [CI_W-1:0]    ci;
  logic [1:0]         tap;
  logic [1:0]         mode_q, mode_eff;
  logic [D_W-1:0]     drain_cnt;
  logic               k3, tap_last, ci_last, x_last, y_last, co_last, beat_last;
  logic               accept, fire, adv;
  logic               pad_nxt;
  logic [ADDR_W-1:0]  rd_addr_nxt, px_addr_nxt;
  logic [WADDR_W-1:0] w_addr_nxt;
  int                 d, yy, xx;

  logic               beat_v, rd_en_q, pad_q, acc_clr_q, acc_last_q, busy_q, done_q;
  logic [ADDR_W-1:0]  rd_addr_q, px_addr_q;
  logic [WADDR_W-1:0] w_addr_q;
  logic [PIPE_LAT-1:0] wv;
  logic [ADDR_W-1:0]  wa [PIPE_LAT];

  // Mode is taken live from the port on the accepting edge so the first beat needs no extra cycle.
  always_comb begin
    adv         = !bus.stall;
    mode_eff    = (state == IDLE) ? bus.mode : mode_q;
    k3          = (mode_eff == 2'd1) || (mode_eff == 2'd2);
    tap_last    = tap == (k3 ? 2'd2 : 2'd0);
    ci_last     = ci == CI_W'(CH_IN - 1);
    x_last      = x == P_W'(FM_W - 1);
    y_last      = y == P_W'(FM_W - 1);
    co_last     = co == CO_W'(CH_OUT - 1);
    beat_last   = tap_last && ci_last && x_last && y_last && co_last;
    accept      = (state == IDLE) && bus.start;
    fire        = adv && ((state == RUN) || accept);
    d           = k3 ? int'(tap) - 1 : 0;
    yy          = int'(y) + ((mode_eff == 2'd1) ? d : 0);
    xx          = int'(x) + ((mode_eff == 2'd2) ? d : 0);
    pad_nxt     = (yy < 0) || (yy >= FM_W) || (xx < 0) || (xx >= FM_W);
    rd_addr_nxt = pad_nxt ? '0 : ADDR_W'(int'(ci) * FM2 + yy * FM_W + xx);
    w_addr_nxt  = WADDR_W'((int'(co) * CH_IN + int'(ci)) * (k3 ? 3 : 1) + int'(tap));
    px_addr_nxt = ADDR_W'(int'(co) * FM2 + int'(y) * FM_W + int'(x));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (fire && beat_last) ? DRAIN : RUN;
      RUN:     if (fire && beat_last) state_nxt = DRAIN;
      DRAIN:   if (adv && drain_cnt == D_W'(PIPE_LAT - 1)) state_nxt = DONE;
      DONE:    if (adv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (accept) mode_q <= bus.mode;
      if (state != DRAIN) drain_cnt <= '0;
      else if (adv)       drain_cnt <= drain_cnt + D_W'(1);
      if (accept)                        busy_q <= 1'b1;
      else if (state == DONE && adv)     busy_q <= 1'b0;
      if (adv) done_q <= (state == DONE);
    end
  end

  // Loop nest counters; all wrap to zero after the final beat, ready for the next layer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      co <= '0; y <= '0; x <= '0; ci <= '0; tap <= '0;
    end else if (fire) begin
      if (!tap_last) tap <= tap + 2'd1;
      else begin
        tap <= '0;
        if (!ci_last) ci <= ci + CI_W'(1);
        else begin
          ci <= '0;
          if (!x_last) x <= x + P_W'(1);
          else begin
            x <= '0;
            if (!y_last) y <= y + P_W'(1);
            else begin
              y  <= '0;
              co <= co_last ? '0 : co + CO_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_v     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      pad_q      <= 1'b0;
      w_addr_q   <= '0;
      acc_clr_q  <= 1'b0;
      acc_last_q <= 1'b0;
      px_addr_q  <= '0;
    end else if (adv) begin
      beat_v  <= fire;
      rd_en_q <= fire && !pad_nxt;
      if (fire) begin
        rd_addr_q  <= rd_addr_nxt;
        pad_q      <= pad_nxt;
        w_addr_q   <= w_addr_nxt;
        acc_clr_q  <= (ci == '0) && (tap == 2'd0);
        acc_last_q <= tap_last && ci_last;
        px_addr_q  <= px_addr_nxt;
      end
    end
  end

  // Write-back delay line: samples each displayed beat, so stalls never drop or duplicate writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) wa[i] <= '0;
    end else if (adv) begin
      wv[0] <= beat_v && acc_last_q;
      wa[0] <= px_addr_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wv[i] <= wv[i-1];
        wa[i] <= wa[i-1];
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rd_en    = rd_en_q && adv;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.pad      = pad_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.acc_clr  = acc_clr_q;
  assign bus.acc_last = acc_last_q;
  assign bus.wr_en    = wv[PIPE_LAT-1] && adv;
  assign bus.wr_addr  = wa[PIPE_LAT-1];
  assign bus.done     = done_q && adv;
endmodule

// File: tb/tb_sqnxt_conv_addr_seq.sv
// tb/tb_sqnxt_conv_addr_seq.sv - directed bench for sqnxt_conv_addr_seq (FM_W=4, CH_IN=2, CH_OUT=2)
module tb_sqnxt_conv_addr_seq;
  localparam int FM_W = 4, CH_IN = 2, CH_OUT = 2, ADDR_W = 10, WADDR_W = 8, PIPE_LAT = 5;
  localparam int NPIX = CH_OUT * FM_W * FM_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sqnxt_conv_addr_seq_if #(.ADDR_W(ADDR_W), .WADDR_W(WADDR_W)) bus ();

  sqnxt_conv_addr_seq #(
    .FM_W(FM_W), .CH_IN(CH_IN), .CH_OUT(CH_OUT),
    .ADDR_W(ADDR_W), .WADDR_W(WADDR_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int r_stall[256], r_rd_en[256], r_rd_addr[256], r_pad[256], r_w_addr[256];
  int r_acc_clr[256], r_acc_last[256], r_wr_en[256], r_wr_addr[256], r_busy[256], r_done[256];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int md, input int j, output int addr, output int pd,
                                output int wa, output int clr, output int lst);
    int k, tap, ci, x, y, co, dd, yy, xx;
    k   = (md == 1 || md == 2) ? 3 : 1;
    tap = j % k;
    ci  = (j / k) % CH_IN;
    x   = (j / (k * CH_IN)) % FM_W;
    y   = (j / (k * CH_IN * FM_W)) % FM_W;
    co  = j / (k * CH_IN * FM_W * FM_W);
    dd  = (k == 3) ? tap - 1 : 0;
    yy  = y + ((md == 1) ? dd : 0);
    xx  = x + ((md == 2) ? dd : 0);
    pd  = (yy < 0 || yy >= FM_W || xx < 0 || xx >= FM_W) ? 1 : 0;
    addr = pd ? 0 : ci * FM_W * FM_W + yy * FM_W + xx;
    wa  = (co * CH_IN + ci) * k + tap;
    clr = (ci == 0 && tap == 0) ? 1 : 0;
    lst = (ci == CH_IN - 1 && tap == k - 1) ? 1 : 0;
  endfunction

  // Cycle c (1-based) is the c-th cycle after the edge that samples start.
  task automatic run_layer(input int md, input int stall_start, input int st0, input int stn0,
                           input int st1, input int stn1, input int rs_cyc, input int ncyc);
    @(posedge clk); #1;
    bus.mode  = 2'(md);
    bus.start = 1'b1;
    bus.stall = 1'(stall_start);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode  = (md == 2) ? 2'd1 : 2'd2;
    for (int c = 1; c <= ncyc; c++) begin
      bus.stall = ((c >= st0 && c < st0 + stn0) || (c >= st1 && c < st1 + stn1));
      bus.start = (c == rs_cyc);
      @(negedge clk);
      r_stall[c]    = int'(bus.stall);
      r_rd_en[c]    = int'(bus.rd_en);
      r_rd_addr[c]  = int'(bus.rd_addr);
      r_pad[c]      = int'(bus.pad);
      r_w_addr[c]   = int'(bus.w_addr);
      r_acc_clr[c]  = int'(bus.acc_clr);
      r_acc_last[c] = int'(bus.acc_last);
      r_wr_en[c]    = int'(bus.wr_en);
      r_wr_addr[c]  = int'(bus.wr_addr);
      r_busy[c]     = int'(bus.busy);
      r_done[c]     = int'(bus.done);
      @(posedge clk); #1;
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic check_run(input int md, input int ncyc, input int exp_done, input string tn);
    int k, nb, nw, nd, first_done, addr, pd, wa, clr, lst, c;
    int q[$];
    k  = (md == 1 || md == 2) ? 3 : 1;
    nb = NPIX * CH_IN * k;
    for (int i = 1; i <= ncyc; i++) if (r_stall[i] == 0) q.push_back(i);
    if (q.size() < nb + PIPE_LAT) begin
      check_eq({tn, " beat window"}, q.size(), nb + PIPE_LAT);
      return;
    end
    for (int j = 0; j < nb; j++) begin
      model(md, j, addr, pd, wa, clr, lst);
      c = q[j];
      check_eq($sformatf("%s rd_en[%0d]", tn, j), r_rd_en[c], 1 - pd);
      check_eq($sformatf("%s rd_addr[%0d]", tn, j), r_rd_addr[c], addr);
      check_eq($sformatf("%s pad[%0d]", tn, j), r_pad[c], pd);
      check_eq($sformatf("%s w_addr[%0d]", tn, j), r_w_addr[c], wa);
      check_eq($sformatf("%s acc_clr[%0d]", tn, j), r_acc_clr[c], clr);
      check_eq($sformatf("%s acc_last[%0d]", tn, j), r_acc_last[c], lst);
    end
    for (int p = 0; p < NPIX; p++) begin
      c = q[(p + 1) * CH_IN * k - 1 + PIPE_LAT];
      check_eq($sformatf("%s wr_en pix%0d", tn, p), r_wr_en[c], 1);
      check_eq($sformatf("%s wr_addr pix%0d", tn, p), r_wr_addr[c], p);
    end
    nw = 0; nd = 0; first_done = -1;
    for (int i = 1; i <= ncyc; i++) begin
      nw += r_wr_en[i];
      if (r_done[i] != 0) begin
        nd++;
        if (first_done < 0) first_done = i;
      end
      if (r_stall[i] != 0) begin
        check_eq($sformatf("%s stalled rd_en c%0d", tn, i), r_rd_en[i], 0);
        check_eq($sformatf("%s stalled wr_en c%0d", tn, i), r_wr_en[i], 0);
      end
    end
    check_eq({tn, " write count"}, nw, NPIX);
    check_eq({tn, " done pulses"}, nd, 1);
    check_eq({tn, " done cycle"}, first_done, exp_done);
    check_eq({tn, " busy first"}, r_busy[1], 1);
    check_eq({tn, " busy before done"}, r_busy[exp_done - 1], 1);
    check_eq({tn, " busy at done"}, r_busy[exp_done], 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.stall = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset busy", int'(bus.busy), 0);
    check_eq("reset rd_en", int'(bus.rd_en), 0);
    check_eq("reset rd_addr", int'(bus.rd_addr), 0);
    check_eq("reset w_addr", int'(bus.w_addr), 0);
    check_eq("reset wr_en", int'(bus.wr_en), 0);
    check_eq("reset done", int'(bus.done), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle after reset busy", int'(bus.busy), 0);

    // T1: 1x1 baseline
    run_layer(0, 0, 0, 0, 0, 0, 0, 80);
    check_run(0, 80, 70, "T1");
    check_eq("T1 rd_addr b0", r_rd_addr[1], 0);
    check_eq("T1 rd_addr b1", r_rd_addr[2], 16);
    check_eq("T1 rd_addr b2", r_rd_addr[3], 1);
    check_eq("T1 rd_addr b3", r_rd_addr[4], 17);
    check_eq("T1 w_addr b1", r_w_addr[2], 1);
    check_eq("T1 w_addr b32", r_w_addr[33], 2);
    check_eq("T1 w_addr b33", r_w_addr[34], 3);
    check_eq("T1 first write", r_wr_en[7], 1);

    // T2: 3x1, taps along y
    run_layer(1, 0, 0, 0, 0, 0, 0, 210);
    check_run(1, 210, 198, "T2");
    check_eq("T2 pad b0", r_pad[1], 1);
    check_eq("T2 rd_en b0", r_rd_en[1], 0);
    check_eq("T2 rd_addr b1", r_rd_addr[2], 0);
    check_eq("T2 rd_addr b2", r_rd_addr[3], 4);
    for (int j = 0; j < 6; j++) check_eq($sformatf("T2 w_addr b%0d", j), r_w_addr[j + 1], j);
    check_eq("T2 pad y3 tap2", r_pad[75], 1);

    // T3: 1x3, taps along x
    run_layer(2, 0, 0, 0, 0, 0, 0, 210);
    check_run(2, 210, 198, "T3");
    check_eq("T3 pad x0 tap0", r_pad[1], 1);
    check_eq("T3 pad x3 tap2", r_pad[21], 1);
    check_eq("T3 rd_addr (1,1) tap0", r_rd_addr[31], 4);
    check_eq("T3 rd_addr (1,1) tap1", r_rd_addr[32], 5);
    check_eq("T3 rd_addr (1,1) tap2", r_rd_addr[33], 6);

    // T4: stall 3 cycles at beat 10, 2 cycles during drain
    run_layer(0, 0, 11, 3, 68, 2, 0, 85);
    check_run(0, 85, 75, "T4");

    // T5: asynchronous reset at beat 20, then a clean restart
    run_layer(0, 0, 0, 0, 0, 0, 0, 21);
    #1 rst = 1'b0;
    #1;
    check_eq("T5 abort busy", int'(bus.busy), 0);
    check_eq("T5 abort rd_en", int'(bus.rd_en), 0);
    check_eq("T5 abort rd_addr", int'(bus.rd_addr), 0);
    check_eq("T5 abort acc_last", int'(bus.acc_last), 0);
    check_eq("T5 abort wr_en", int'(bus.wr_en), 0);
    check_eq("T5 abort wr_addr", int'(bus.wr_addr), 0);
    @(negedge clk);
    rst = 1'b1;
    run_layer(0, 0, 0, 0, 0, 0, 0, 80);
    check_run(0, 80, 70, "T5");

    // T6: start re-pulsed mid-run is ignored; mode 3 behaves as 1x1
    run_layer(0, 0, 0, 0, 0, 0, 10, 80);
    check_run(0, 80, 70, "T6a");
    run_layer(3, 0, 0, 0, 0, 0, 0, 80);
    check_run(3, 80, 70, "T6b");

    // T7: start and stall together in idle
    run_layer(0, 1, 0, 0, 0, 0, 0, 80);
    check_eq("T7 busy c1", r_busy[1], 1);
    check_eq("T7 rd_en c1", r_rd_en[1], 0);
    check_eq("T7 rd_en b0", r_rd_en[2], 1);
    check_eq("T7 rd_addr b1", r_rd_addr[3], 16);
    check_eq("T7 done cycle", r_done[71], 1);
    check_eq("T7 no early done", r_done[70], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
